j4_boot_loader: RTL and testbench
=================================

Name: j4_boot_loader

Overview:
Byte-stream program loader that sits directly upstream of the j4 core's instruction/data RAM. It receives a framed program image as a valid/ready byte stream, assembles 16-bit words, and writes them into RAM through a dedicated write port. It verifies an XOR checksum, then asserts cpu_run to release the core from hold. The core must not fetch while cpu_run is low.

Parameters:
WIDTH, 16, RAM data word width; must equal `WIDTH from common.h.
ADDR_W, 16, RAM address width.
LOAD_BASE, 0, first RAM address written; later words go to LOAD_BASE+1, LOAD_BASE+2, and so on.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_valid  input  1  rx_data holds a valid byte.
rx_data  input  8  incoming stream byte.
rx_ready  output  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready.
restart  input  1  single-cycle pulse; returns the loader from RUN or ERR to IDLE.
mem_we  output  1  RAM write strobe.
mem_addr  output  ADDR_W  RAM write address.
mem_wdata  output  WIDTH  RAM write data.
cpu_run  output  1  high means the core may execute.
err  output  1  checksum failure flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, err=0.
  - Word counter=0; checksum=0.
  - Reset mid-load abandons the frame. RAM contents already written are not rolled back.
- Frame format:
  - Bytes in order: 0xA5, LEN_HI, LEN_LO, then LEN words sent high byte first, then CSUM.
  - LEN is unsigned, 0..65535.
  - CSUM = XOR of LEN_HI, LEN_LO and every data byte. 0xA5 is excluded.
- States:
  - IDLE: waiting for the frame start byte.
  - LEN_HI, LEN_LO: receiving the length.
  - D_HI, D_LO: receiving one data word.
  - CSUM: receiving the checksum byte.
  - RUN, ERR: terminal states, left only via restart or reset.
- rx_ready is combinational: 1 in IDLE, LEN_HI, LEN_LO, D_HI, D_LO and CSUM; 0 in RUN and ERR.
- Transitions (each on an accepted byte):
  - IDLE: 0xA5 goes to LEN_HI and clears the checksum. Any other byte is discarded and the state stays IDLE.
  - LEN_HI goes to LEN_LO.
  - LEN_LO goes to D_HI if LEN != 0, else to CSUM.
  - D_HI: latch the high byte; go to D_LO.
  - D_LO: schedule the word write. If it was the last word, go to CSUM; otherwise go to D_HI.
  - CSUM: match goes to RUN; mismatch goes to ERR.
- Write timing:
  - mem_we is registered and high for exactly one cycle, the cycle after the D_LO byte is accepted.
  - In that cycle mem_addr = LEN_BASE-relative address (LOAD_BASE + word index) and mem_wdata = {hi, lo}.
  - Outside write cycles mem_we=0; mem_addr and mem_wdata hold their last values.
- Address arithmetic: LOAD_BASE + index modulo 2^ADDR_W, so the address wraps silently past the top of memory.
- Back-to-back bytes, one per cycle, must be sustained with no bubbles. Gaps in rx_valid only stall the FSM.
- RUN: cpu_run=1 from the cycle after the CSUM byte is accepted; err=0.
- ERR: err=1 from the cycle after the CSUM byte is accepted; cpu_run=0.
- restart:
  - In RUN or ERR: next cycle state=IDLE, cpu_run=0, err=0, counters cleared.
  - In any other state: ignored.
- If restart and an accepted byte occur in the same cycle, restart cannot coincide with acceptance, because rx_ready=0 in RUN and ERR.
- A new frame is loaded only after restart. It always starts again at LOAD_BASE.

Test Plan:
1. Bytes A5 00 02 12 34 56 78 0A, one per cycle -> mem_we pulses with addr 0000 and data 1234, then addr 0001 and data 5678. cpu_run=1 one cycle after 0A is accepted; err=0.
2. A5 00 00 00 -> no mem_we pulse; cpu_run=1.
3. Same as scenario 1 but CSUM=0B -> both writes still occur, err=1, cpu_run=0, rx_ready=0. Then a restart pulse -> err=0 and rx_ready=1 with state IDLE; a following valid frame loads normally.
4. Prefix bytes 00 FF 5A, then the frame from scenario 1 -> prefix bytes discarded; identical writes and cpu_run as scenario 1.
5. A5 00 02 12, then rst_n low for 2 cycles, then 34 -> all outputs 0 during reset. The 34 is discarded in IDLE and no mem_we occurs.
6. LOAD_BASE=FFFF with A5 00 02 AA BB CC DD 02 -> writes go to addr FFFF with data AABB, then addr 0000 with data CCDD. Randomised rx_valid gaps produce the same writes; rx_valid held high in RUN accepts nothing.

Source files
------------

// File: rtl/j4_boot_loader.sv
// Framed byte-stream program loader for the j4 core: assembles 16-bit words,
// writes them into RAM from LOAD_BASE upward and releases the core on a good checksum.
module j4_boot_loader #(
  parameter int                WIDTH     = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_run,
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_D_HI   = 3'd3;
  localparam logic [2:0] S_D_LO   = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_RUN    = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  csum;
  logic [7:0]  hi;
  logic        accept;
  logic        terminal;

  assign terminal = (state == S_RUN) || (state == S_ERR);
  assign rx_ready = !terminal;
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      hi        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (restart && terminal) begin
        state   <= S_IDLE;
        cpu_run <= 1'b0;
        err     <= 1'b0;
        len     <= '0;
        idx     <= '0;
        csum    <= '0;
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            // Anything other than the start byte is silently dropped.
            if (rx_data == 8'hA5) begin
              state <= S_LEN_HI;
              csum  <= '0;
              idx   <= '0;
            end
          end
          S_LEN_HI: begin
            len[15:8] <= rx_data;
            csum      <= csum ^ rx_data;
            state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len[7:0] <= rx_data;
            csum     <= csum ^ rx_data;
            state    <= ({len[15:8], rx_data} != 16'd0) ? S_D_HI : S_CSUM;
          end
          S_D_HI: begin
            hi    <= rx_data;
            csum  <= csum ^ rx_data;
            state <= S_D_LO;
          end
          S_D_LO: begin
            // Address wraps modulo 2^ADDR_W past the top of memory.
            mem_we    <= 1'b1;
            mem_addr  <= LOAD_BASE + ADDR_W'(idx);
            mem_wdata <= WIDTH'({hi, rx_data});
            csum      <= csum ^ rx_data;
            idx       <= idx + 16'd1;
            state     <= (idx + 16'd1 == len) ? S_CSUM : S_D_HI;
          end
          S_CSUM: begin
            if (csum == rx_data) begin
              state   <= S_RUN;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_j4_boot_loader.sv
// Scoreboard bench for j4_boot_loader: two instances (base 0 and base FFFF),
// expected writes/status queued by stimulus and checked by a single monitor.
module tb_j4_boot_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    bit sel;
    bit zero;
    bit rdy;
    bit run;
    bit er;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic [7:0]  rx_data0 = '0, rx_data1 = '0;
  logic        restart0 = 1'b0, restart1 = 1'b0;
  logic        rx_ready0, rx_ready1;
  logic        mem_we0, mem_we1;
  logic [15:0] mem_addr0, mem_addr1;
  logic [15:0] mem_wdata0, mem_wdata1;
  logic        cpu_run0, cpu_run1;
  logic        err0, err1;

  wr_t wq0[$];
  wr_t wq1[$];
  st_t sq[$];
  int  checks = 0;
  int  failures = 0;
  bit  end_req = 1'b0;
  bit  end_done = 1'b0;

  always #5 clk = ~clk;

  j4_boot_loader #(.WIDTH(16), .ADDR_W(16), .LOAD_BASE(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid0), .rx_data(rx_data0),
    .rx_ready(rx_ready0), .restart(restart0), .mem_we(mem_we0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .cpu_run(cpu_run0), .err(err0)
  );

  j4_boot_loader #(.WIDTH(16), .ADDR_W(16), .LOAD_BASE(16'hFFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid1), .rx_data(rx_data1),
    .rx_ready(rx_ready1), .restart(restart1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .cpu_run(cpu_run1), .err(err1)
  );

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    if (mem_we0) begin
      checks++;
      if (wq0.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write0 got addr=%h data=%h want no write", mem_addr0, mem_wdata0);
      end else begin
        wr_t w;
        w = wq0.pop_front();
        if (mem_addr0 !== w.a || mem_wdata0 !== w.d) begin
          failures++;
          $display("FAIL write0 got addr=%h data=%h want addr=%h data=%h", mem_addr0, mem_wdata0, w.a, w.d);
        end
      end
    end
    if (mem_we1) begin
      checks++;
      if (wq1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write1 got addr=%h data=%h want no write", mem_addr1, mem_wdata1);
      end else begin
        wr_t w;
        w = wq1.pop_front();
        if (mem_addr1 !== w.a || mem_wdata1 !== w.d) begin
          failures++;
          $display("FAIL write1 got addr=%h data=%h want addr=%h data=%h", mem_addr1, mem_wdata1, w.a, w.d);
        end
      end
    end
    while (sq.size() > 0) begin
      st_t s;
      logic [2:0] act;
      logic [2:0] req;
      s   = sq.pop_front();
      act = s.sel ? {rx_ready1, cpu_run1, err1} : {rx_ready0, cpu_run0, err0};
      req = {s.rdy, s.run, s.er};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL status%0d got rdy/run/err=%b want %b", s.sel, act, req);
      end
      if (s.zero) begin
        checks++;
        if ({mem_we0, mem_addr0, mem_wdata0} !== 33'd0) begin
          failures++;
          $display("FAIL reset_mem got we=%b addr=%h data=%h want all zero", mem_we0, mem_addr0, mem_wdata0);
        end
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (wq0.size() != 0 || wq1.size() != 0) begin
        failures++;
        $display("FAIL missing_writes got pending=%0d/%0d want 0/0", wq0.size(), wq1.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic probe(input bit sel, input bit zero, input bit rdy, input bit run, input bit er);
    st_t s;
    s = '{sel: sel, zero: zero, rdy: rdy, run: run, er: er};
    sq.push_back(s);
  endtask

  task automatic send(input bit sel, input logic [7:0] b);
    @(negedge clk);
    if (sel) begin rx_valid1 = 1'b1; rx_data1 = b; end
    else begin rx_valid0 = 1'b1; rx_data0 = b; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      if (sel) rx_valid1 = 1'b0; else rx_valid0 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_restart(input bit sel);
    @(negedge clk);
    if (sel) begin rx_valid1 = 1'b0; restart1 = 1'b1; end
    else begin rx_valid0 = 1'b0; restart0 = 1'b1; end
    @(posedge clk); #1;
    probe(sel, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    restart0 = 1'b0;
    restart1 = 1'b0;
  endtask

  // Scenario-1 frame on dut0; csum selects a good (0A) or bad (0B) checksum.
  task automatic frame1(input logic [7:0] csum);
    logic [7:0] f[8];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    f[7] = csum;
    wq0.push_back('{a: 16'h0000, d: 16'h1234});
    wq0.push_back('{a: 16'h0001, d: 16'h5678});
    for (int i = 0; i < 8; i++) send(1'b0, f[i]);
  endtask

  initial begin
    logic [7:0] g[8];
    g = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    probe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-word frame, good checksum
    frame1(8'h0A);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 2);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b0);

    // 2: empty frame
    send(1'b0, 8'hA5); send(1'b0, 8'h00); send(1'b0, 8'h00); send(1'b0, 8'h00);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b0);

    // 3: bad checksum, restart, then a good frame
    frame1(8'h0B);
    probe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    probe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_restart(1'b0);
    frame1(8'h0A);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b0);

    // 4: junk prefix before the frame
    send(1'b0, 8'h00); send(1'b0, 8'hFF); send(1'b0, 8'h5A);
    probe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame1(8'h0A);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b0);

    // 5: reset mid-frame abandons it
    send(1'b0, 8'hA5); send(1'b0, 8'h00); send(1'b0, 8'h02); send(1'b0, 8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid0 = 1'b0;
    @(posedge clk); #1;
    probe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    probe(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h34);
    idle(1'b0, 3);
    probe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame1(8'h0A);
    probe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b0);

    // 6: base FFFF wraps to 0000; back-to-back, then random gaps
    wq1.push_back('{a: 16'hFFFF, d: 16'hAABB});
    wq1.push_back('{a: 16'h0000, d: 16'hCCDD});
    for (int i = 0; i < 8; i++) send(1'b1, g[i]);
    probe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b1);
    wq1.push_back('{a: 16'hFFFF, d: 16'hAABB});
    wq1.push_back('{a: 16'h0000, d: 16'hCCDD});
    for (int i = 0; i < 8; i++) begin
      idle(1'b1, $urandom_range(0, 2));
      send(1'b1, g[i]);
    end
    probe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // rx_valid held high in RUN: nothing may be accepted
    for (int i = 0; i < 5; i++) send(1'b1, 8'hA5);
    probe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_restart(1'b1);

    idle(1'b0, 2);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!end_done) begin
      failures++;
      $display("FAIL end_check got done=0 want done=1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
